// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter for the register-file write port
//
// Purpose:
//   Shares one register-file write port between NREQ writeback sources
//   (0 = load, 1 = lui, 2 = jump, 3 = alu). Each source presents a
//   valid/ready request; a round-robin arbiter grants one per cycle and the
//   winning write is registered onto wr_* one cycle later. A combinational
//   hazard flag tells the issue stage when rs1/rs2 name a register that is
//   still waiting for, or just receiving, a write.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req_valid  per-source write request               [NREQ]
//   req_rd     packed destination registers           [NREQ*AW], source i at [i*AW +: AW]
//   req_data   packed write data                      [NREQ*DW], source i at [i*DW +: DW]
//   req_ready  one-hot grant, combinational           [NREQ]
//   rs1, rs2   issue-stage read addresses             [AW]
//   hazard     rs1/rs2 matches an in-flight write     (combinational)
//   wr_en      register-file write enable             (registered)
//   wr_addr    register-file write address            (registered)
//   wr_data    register-file write data               (registered)
//   grant_id   source behind the current wr_*         (registered)

module regfile_wb_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_rd,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic [AW-1:0]      rs1,
    input  logic [AW-1:0]      rs2,
    output logic               hazard,
    output logic               wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [DW-1:0]      wr_data,
    output logic [1:0]         grant_id
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;
    logic          gnt_any;
    logic [AW-1:0] sel_rd;
    logic [DW-1:0] sel_data;
    logic [PW-1:0] ptr_next;

    // Round-robin scan starting at ptr. The grant depends only on req_valid
    // and ptr, never on req_ready, so there is no combinational loop with the
    // sources. While reset is held the grant is forced off so no source
    // believes it has been accepted.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx[PW-1:0];
            end
        end
        if (!rst) begin
            gnt_any = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign sel_rd   = req_rd[gnt_idx*AW +: AW];
    assign sel_data = req_data[gnt_idx*DW +: DW];

    // The winner moves to the back of the line: next scan starts just after it.
    assign ptr_next = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            grant_id <= '0;
        end else begin
            if (gnt_any) begin
                ptr      <= ptr_next;
                // x0 writes still consume the grant but never reach the file.
                wr_en    <= (sel_rd != '0);
                wr_addr  <= sel_rd;
                wr_data  <= sel_data;
                grant_id <= 2'(gnt_idx);
            end else begin
                wr_en    <= 1'b0;
            end
        end
    end

    // A register is in flight if any source still wants to write it or it is
    // being written this cycle. x0 is hardwired, so it never stalls issue.
    always_comb begin
        logic hz1;
        logic hz2;
        hz1 = 1'b0;
        hz2 = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && (req_rd[i*AW +: AW] == rs1)) begin
                hz1 = 1'b1;
            end
            if (req_valid[i] && (req_rd[i*AW +: AW] == rs2)) begin
                hz2 = 1'b1;
            end
        end
        if (wr_en && (wr_addr == rs1)) begin
            hz1 = 1'b1;
        end
        if (wr_en && (wr_addr == rs2)) begin
            hz2 = 1'b1;
        end
        hazard = ((rs1 != '0) && hz1) || ((rs2 != '0) && hz2);
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter

module tb_regfile_wb_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [19:0]  req_rd;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic         hazard;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;
    logic [1:0]   grant_id;

    regfile_wb_arbiter #(.NREQ(4), .AW(5), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .hazard    (hazard),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   valid;
        logic [19:0]  rd;
        logic [127:0] data;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [3:0]   exp_ready;
    } vec_t;

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  gid;
    } wr_t;

    vec_t vecs[17];
    wr_t  sb[$];

    int n_pass = 0;
    int n_total = 0;

    logic        cur_en;
    logic [4:0]  cur_addr;
    logic [4:0]  last_addr;
    logic [31:0] last_data;
    logic [1:0]  last_gid;

    function automatic logic [19:0] pack_rd(input int a0, input int a1, input int a2, input int a3);
        return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    function automatic logic [127:0] pack_data(input logic [31:0] d0, input logic [31:0] d1,
                                               input logic [31:0] d2, input logic [31:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic model_hazard();
        logic h;
        h = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && rs1 != 0 && req_rd[i*5 +: 5] == rs1) h = 1'b1;
            if (req_valid[i] && rs2 != 0 && req_rd[i*5 +: 5] == rs2) h = 1'b1;
        end
        if (cur_en && rs1 != 0 && cur_addr == rs1) h = 1'b1;
        if (cur_en && rs2 != 0 && cur_addr == rs2) h = 1'b1;
        return h;
    endfunction

    // Called just after a falling edge: drive, check combinational outputs,
    // queue the expected write, then check the registered port one edge later.
    task automatic apply(input vec_t v, input int n);
        wr_t e;
        int  g;
        string tag;
        tag = $sformatf("v%0d", n);
        req_valid = v.valid;
        req_rd    = v.rd;
        req_data  = v.data;
        rs1       = v.rs1;
        rs2       = v.rs2;
        #1;
        chk({tag, ".ready"}, 128'(req_ready), 128'(v.exp_ready));
        chk({tag, ".hazard"}, 128'(hazard), 128'(model_hazard()));
        g = -1;
        for (int i = 0; i < 4; i++) if (v.exp_ready[i]) g = i;
        if (g >= 0) begin
            e.en      = (v.rd[g*5 +: 5] != 0);
            e.addr    = v.rd[g*5 +: 5];
            e.data    = v.data[g*32 +: 32];
            e.gid     = 2'(g);
            last_addr = e.addr;
            last_data = e.data;
            last_gid  = e.gid;
        end else begin
            e.en   = 1'b0;
            e.addr = last_addr;
            e.data = last_data;
            e.gid  = last_gid;
        end
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if (sb.size() == 0) begin
            $display("FAIL %s.sb: scoreboard empty", tag);
        end else begin
            n_pass++;
            e = sb.pop_front();
            chk({tag, ".wr_en"},    128'(wr_en),    128'(e.en));
            chk({tag, ".wr_addr"},  128'(wr_addr),  128'(e.addr));
            chk({tag, ".wr_data"},  128'(wr_data),  128'(e.data));
            chk({tag, ".grant_id"}, 128'(grant_id), 128'(e.gid));
            cur_en   = e.en;
            cur_addr = e.addr;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Single alu write, then idle.
        vecs[0]  = '{4'b1000, pack_rd(0,0,0,5), pack_data(0,0,0,32'hDEADBEEF), 5'd0, 5'd0, 4'b1000};
        vecs[1]  = '{4'b0000, pack_rd(0,0,0,5), pack_data(0,0,0,32'hDEADBEEF), 5'd0, 5'd5, 4'b0000};
        // All four valid from ptr=0, each drops after its grant.
        vecs[2]  = '{4'b1111, pack_rd(1,2,3,4), pack_data(32'h10,32'h20,32'h30,32'h40), 5'd0, 5'd0, 4'b0001};
        vecs[3]  = '{4'b1110, pack_rd(1,2,3,4), pack_data(32'h10,32'h20,32'h30,32'h40), 5'd3, 5'd0, 4'b0010};
        vecs[4]  = '{4'b1100, pack_rd(1,2,3,4), pack_data(32'h10,32'h20,32'h30,32'h40), 5'd0, 5'd0, 4'b0100};
        vecs[5]  = '{4'b1000, pack_rd(1,2,3,4), pack_data(32'h10,32'h20,32'h30,32'h40), 5'd0, 5'd0, 4'b1000};
        vecs[6]  = '{4'b0000, pack_rd(1,2,3,4), pack_data(32'h10,32'h20,32'h30,32'h40), 5'd4, 5'd0, 4'b0000};
        // Move ptr to 1, then sources 0 and 3 held for six cycles.
        vecs[7]  = '{4'b0001, pack_rd(9,0,0,0), pack_data(32'h99,0,0,0), 5'd0, 5'd0, 4'b0001};
        vecs[8]  = '{4'b1001, pack_rd(10,0,0,11), pack_data(32'hA0,0,0,32'hB0), 5'd0, 5'd0, 4'b1000};
        vecs[9]  = '{4'b1001, pack_rd(10,0,0,11), pack_data(32'hA1,0,0,32'hB1), 5'd0, 5'd0, 4'b0001};
        vecs[10] = '{4'b1001, pack_rd(10,0,0,11), pack_data(32'hA2,0,0,32'hB2), 5'd0, 5'd0, 4'b1000};
        vecs[11] = '{4'b1001, pack_rd(10,0,0,11), pack_data(32'hA3,0,0,32'hB3), 5'd0, 5'd0, 4'b0001};
        vecs[12] = '{4'b1001, pack_rd(10,0,0,11), pack_data(32'hA4,0,0,32'hB4), 5'd0, 5'd0, 4'b1000};
        vecs[13] = '{4'b1001, pack_rd(10,0,0,11), pack_data(32'hA5,0,0,32'hB5), 5'd0, 5'd0, 4'b0001};
        // x0 write from source 1; then 0 and 1 compete to show ptr moved to 2.
        vecs[14] = '{4'b0010, pack_rd(0,0,0,0), pack_data(0,32'h1234,0,0), 5'd0, 5'd0, 4'b0010};
        vecs[15] = '{4'b0011, pack_rd(12,13,0,0), pack_data(32'hC0,32'hC1,0,0), 5'd0, 5'd0, 4'b0001};
        vecs[16] = '{4'b0000, pack_rd(0,0,0,0), pack_data(0,0,0,0), 5'd0, 5'd0, 4'b0000};

        // Reset state, with requests present to show they are ignored.
        rst       = 1'b0;
        req_valid = 4'b1111;
        req_rd    = pack_rd(1,2,3,4);
        req_data  = pack_data(32'h10,32'h20,32'h30,32'h40);
        rs1       = '0;
        rs2       = '0;
        cur_en    = 1'b0;
        cur_addr  = '0;
        last_addr = '0;
        last_data = '0;
        last_gid  = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.ready",    128'(req_ready), 128'(4'b0000));
        chk("rst.wr_en",    128'(wr_en),     128'(1'b0));
        chk("rst.wr_addr",  128'(wr_addr),   128'(5'd0));
        chk("rst.wr_data",  128'(wr_data),   128'(32'd0));
        chk("rst.grant_id", 128'(grant_id),  128'(2'd0));
        req_valid = '0;
        rst = 1'b1;

        for (int n = 0; n < 17; n++) begin
            apply(vecs[n], n);
        end

        // Hazard tracking through the write cycle (ptr=1 here).
        req_valid = 4'b0100;
        req_rd    = pack_rd(0,0,7,0);
        req_data  = pack_data(0,0,32'h77,0);
        rs1       = 5'd7;
        rs2       = 5'd0;
        #1;
        chk("hz.pending",     128'(hazard),    128'(1'b1));
        chk("hz.ready",       128'(req_ready), 128'(4'b0100));
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("hz.wr_en",       128'(wr_en),     128'(1'b1));
        chk("hz.wr_addr",     128'(wr_addr),   128'(5'd7));
        chk("hz.writing",     128'(hazard),    128'(1'b1));
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("hz.clear",       128'(hazard),    128'(1'b0));
        chk("hz.clear_wr_en", 128'(wr_en),     128'(1'b0));
        // x0 target with rs1=0: never a hazard (ptr=3, so source 1 wins).
        req_valid = 4'b0010;
        req_rd    = pack_rd(0,0,0,0);
        req_data  = pack_data(0,32'h55,0,0);
        rs1       = 5'd0;
        #1;
        chk("hz.x0",          128'(hazard),    128'(1'b0));
        chk("hz.x0_ready",    128'(req_ready), 128'(4'b0010));
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("hz.x0_wr_en",    128'(wr_en),     128'(1'b0));
        chk("hz.x0_gid",      128'(grant_id),  128'(2'd1));

        // Reset asserted between edges right after a grant (ptr=2).
        @(negedge clk);
        req_valid = 4'b1111;
        req_rd    = pack_rd(1,2,3,4);
        req_data  = pack_data(32'h10,32'h20,32'h30,32'h40);
        #1;
        chk("mr.ready_pre",   128'(req_ready), 128'(4'b0100));
        @(posedge clk);
        #1;
        chk("mr.wr_en_pre",   128'(wr_en),     128'(1'b1));
        #1;
        rst = 1'b0;
        #1;
        chk("mr.wr_en",       128'(wr_en),     128'(1'b0));
        chk("mr.ready",       128'(req_ready), 128'(4'b0000));
        chk("mr.wr_addr",     128'(wr_addr),   128'(5'd0));
        chk("mr.grant_id",    128'(grant_id),  128'(2'd0));
        @(posedge clk);
        #1;
        chk("mr.held_wr_en",  128'(wr_en),     128'(1'b0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mr.first_ready", 128'(req_ready), 128'(4'b0001));
        @(posedge clk);
        @(negedge clk);
        chk("mr.first_wr_en", 128'(wr_en),     128'(1'b1));
        chk("mr.first_addr",  128'(wr_addr),   128'(5'd1));
        chk("mr.first_data",  128'(wr_data),   128'(32'h10));
        chk("mr.first_gid",   128'(grant_id),  128'(2'd0));
        req_valid = 4'b0000;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between four writeback sources: load data, LUI immediate, jump return address and ALU result.
- Uses a valid/ready handshake per source, round-robin arbitration and a registered write port with one-cycle latency.
- Flags read-after-write hazards on rs1 and rs2 against in-flight writes so the issue stage can stall.
- Sits between the execute/memory stages and the register file write inputs.

Parameters:
- NREQ, 4, number of writeback requesters. Index 0 = load, 1 = lui, 2 = jump, 3 = alu.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-source write request.
- req_rd  input  NREQ*AW  destination register of each source, packed; source i occupies bits [i*AW +: AW].
- req_data  input  NREQ*DW  write data of each source, packed; source i occupies bits [i*DW +: DW].
- req_ready  output  NREQ  one-hot grant; combinational.
- rs1  input  AW  issue-stage read address 1.
- rs2  input  AW  issue-stage read address 2.
- hazard  output  1  rs1 or rs2 matches an in-flight write; combinational.
- wr_en  output  1  register-file write enable; registered.
- wr_addr  output  AW  register-file write address; registered.
- wr_data  output  DW  register-file write data; registered.
- grant_id  output  2  index of the source behind the current wr_*; registered.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous release):
  - wr_en=0, wr_addr=0, wr_data=0, grant_id=0.
  - Round-robin pointer ptr=0.
  - req_ready is 0 while rst=0.
- Handshake:
  - A transfer occurs on a rising edge where req_valid[i] & req_ready[i] = 1.
  - A source holds valid, rd and data stable until it is granted; the arbiter never drops a held request.
  - A source may deassert valid only after its transfer.
- Arbitration (every cycle, combinational):
  - Scan indices ptr, ptr+1, ... mod NREQ.
  - Grant the first index with req_valid set. Exactly one req_ready bit is high if any valid is high, none otherwise.
  - The grant does not depend on req_ready feedback.
- Pointer update:
  - On a transfer from source g, ptr <= (g+1) mod NREQ.
  - With no transfer, ptr holds.
  - This guarantees each requester waits at most NREQ-1 grants.
- Write port, one-cycle latency:
  - On a transfer: wr_en <= (rd != 0), wr_addr <= rd, wr_data <= data, grant_id <= g.
  - With no transfer: wr_en <= 0; wr_addr, wr_data and grant_id hold.
  - Writes to x0 are accepted and consume a grant, but never assert wr_en.
  - Throughput is one write per cycle; back-to-back grants give wr_en high on consecutive cycles.
- Same rd from multiple sources: no merging. Each is written in grant order; the last written wins.
- Hazard (combinational):
  - hazard=1 if, for any nonzero rs (rs1 or rs2), either of these holds:
    - some req_valid[i] has req_rd[i]==rs, or
    - wr_en=1 and wr_addr==rs.
  - rs=0 never raises hazard.
  - hazard is independent of arbitration order.
- Reset mid-operation:
  - Outstanding requests are abandoned: no partial write, wr_en drops immediately and ptr returns to 0.
  - Sources re-present their requests after release.
- No X propagation: with no valid request, req_ready=0 and the outputs are as specified above.

Test Plan:
1. Reset, then a single request on source 3 (alu) with rd=5, data=0xDEADBEEF, held 1 cycle.
   - req_ready=4'b1000 in that cycle.
   - Next cycle: wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, grant_id=3.
   - Following cycle: wr_en=0.
2. All four valid continuously from ptr=0 with rd=1,2,3,4 and data=0x10,0x20,0x30,0x40.
   - Grants occur in order 0,1,2,3 on consecutive cycles.
   - wr_en stays high for 4 cycles with wr_addr 1,2,3,4.
   - Each source drops valid after its grant.
3. Fairness: sources 0 and 3 held valid for 6 cycles starting with ptr=1.
   - Grant sequence is 3,0,3,0,3,0; neither source is granted twice in a row.
4. x0 write: source 1 valid with rd=0, data=0x1234.
   - req_ready[1]=1, next-cycle wr_en=0, and ptr advances to 2.
5. Hazard: source 2 valid with rd=7, rs1=7, rs2=0 → hazard=1.
   - After the grant, hazard stays 1 for the wr_en cycle with wr_addr=7, then goes to 0.
   - rs1=0 with any request targeting x0 → hazard=0.
6. Reset mid-operation: all four valid, rst pulled low asynchronously between clock edges.
   - wr_en=0 and req_ready=0 immediately, with no write.
   - After release, the first grant goes to source 0.
